// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared constants and helpers for the pipelined carry-lookahead adder.
//   CLA_N       default operand width
//   CLA_SEG     default bits resolved per pipeline stage
//   cla_stages  number of pipeline stages for a given width/segment size
//   cla_cfg_ok  true when the width splits evenly into segments
// -----------------------------------------------------------------------------
package cla_pkg;

  localparam int CLA_N   = 64;
  localparam int CLA_SEG = 16;

  function automatic int cla_stages(input int n, input int seg);
    return n / seg;
  endfunction

  function automatic bit cla_cfg_ok(input int n, input int seg);
    return (seg > 0) && (n >= seg) && ((n % seg) == 0);
  endfunction

endpackage

// File: rtl/cla_segment.sv
// -----------------------------------------------------------------------------
// cla_segment
// Combinational SEG-bit carry-lookahead slice.
// Ports:
//   a, b   in  SEG  operand slices (b already conditionally inverted)
//   c_in   in  1    carry into bit 0 of the slice
//   s      out SEG  sum bits
//   c_out  out 1    carry out of the slice, G | P&c_in
//   P      out 1    group propagate (all bits propagate)
//   G      out 1    group generate
// -----------------------------------------------------------------------------
module cla_segment
  import cla_pkg::*;
#(
  parameter int SEG = CLA_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           c_in,
  output logic [SEG-1:0] s,
  output logic           c_out,
  output logic           P,
  output logic           G
);

  logic [SEG-1:0] w_p;
  logic [SEG-1:0] w_g;
  logic [SEG-1:0] w_c;
  logic           w_grp_g;

  assign w_p = a | b;
  assign w_g = a & b;

  // Per-bit carries expressed purely in generate/propagate terms of the
  // lower bits; the loop flattens into the lookahead sum-of-products.
  always_comb begin
    w_c    = '0;
    w_c[0] = c_in;
    for (int i = 1; i < SEG; i++) begin
      w_c[i] = w_g[i-1] | (w_p[i-1] & w_c[i-1]);
    end
  end

  // Group generate: a carry produced somewhere in the slice and propagated
  // through every bit above it.
  always_comb begin
    w_grp_g = 1'b0;
    for (int i = 0; i < SEG; i++) begin
      w_grp_g = w_g[i] | (w_p[i] & w_grp_g);
    end
  end

  assign s     = a ^ b ^ w_c;
  assign P     = &w_p;
  assign G     = w_grp_g;
  assign c_out = w_grp_g | (P & c_in);

endmodule

// File: rtl/pipelined_cla_adder.sv
// -----------------------------------------------------------------------------
// pipelined_cla_adder
// Pipelined carry-lookahead adder/subtractor. An N-bit operation is resolved
// SEG bits per stage over STAGES = N/SEG stages; the carry is registered
// between stages and operand segments are skewed so that segment k is
// resolved in stage k. One operation per cycle, valid/ready with full
// backpressure, latency STAGES cycles.
//
// Optional build macro PIPELINED_CLA_SATURATE_EN adds input 'sat': when set
// and the operation overflows, sum is clamped to the signed extreme.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_valid/ready  operation handshake; in_ready = !out_valid || out_ready
//   x, y            operands (N bits)
//   cin             carry-in, used only for add
//   sub             0: x+y+cin, 1: x+~y+1
//   sat             (macro only) saturate on signed overflow
//   out_valid/ready result handshake
//   sum             N-bit result
//   cout            carry out of bit N-1 (not-borrow for subtract)
//   overflow        signed overflow
// -----------------------------------------------------------------------------
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int N   = CLA_N,
  parameter int SEG = CLA_SEG
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  input  logic         sub,
`ifdef PIPELINED_CLA_SATURATE_EN
  input  logic         sat,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         overflow
);

  localparam int STAGES = cla_stages(N, SEG);
  localparam int L      = STAGES - 1;

  if (!cla_cfg_ok(N, SEG)) begin : g_bad_cfg
    $error("pipelined_cla_adder: N must be a non-zero multiple of SEG");
  end

`ifdef PIPELINED_CLA_SATURATE_EN
  function automatic logic [N-1:0] sat_extreme(input logic neg);
    return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction
`endif

  // Stage registers: entry k holds the state after segment k is resolved.
  logic         r_vld_p [STAGES];
  logic [N-1:0] r_a_p   [STAGES];
  logic [N-1:0] r_b_p   [STAGES];
  logic [N-1:0] r_sum_p [STAGES];
  logic         r_c_p   [STAGES];
  logic         r_ovf;
`ifdef PIPELINED_CLA_SATURATE_EN
  logic         r_sat_p [STAGES];
  logic         w_sat_st [STAGES];
`endif

  // Inputs seen by stage k (stage 0 reads the ports directly).
  logic [N-1:0]   w_a_st   [STAGES];
  logic [N-1:0]   w_b_st   [STAGES];
  logic           w_c_st   [STAGES];
  logic [N-1:0]   w_sum_st [STAGES];

  logic [SEG-1:0] w_seg_s  [STAGES];
  logic           w_seg_co [STAGES];
  logic           w_seg_p  [STAGES];
  logic           w_seg_g  [STAGES];

  logic [N-1:0]   w_sum_nx [STAGES];
  logic           w_cnx    [STAGES];
  logic           w_ovf;
  logic [N-1:0]   w_res;
  logic           w_adv;

  assign out_valid = r_vld_p[L];
  assign sum       = r_sum_p[L];
  assign cout      = r_c_p[L];
  assign overflow  = r_ovf;

  // The whole pipe moves together; a stalled output freezes every stage.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage inputs: subtraction folds into inverted y plus a forced carry-in,
  // so cin and sub need not travel beyond stage 0.
  always_comb begin
    w_a_st[0]   = x;
    w_b_st[0]   = y ^ {N{sub}};
    w_c_st[0]   = sub | cin;
    w_sum_st[0] = '0;
`ifdef PIPELINED_CLA_SATURATE_EN
    w_sat_st[0] = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      w_a_st[k]   = r_a_p[k-1];
      w_b_st[k]   = r_b_p[k-1];
      w_c_st[k]   = r_c_p[k-1];
      w_sum_st[k] = r_sum_p[k-1];
`ifdef PIPELINED_CLA_SATURATE_EN
      w_sat_st[k] = r_sat_p[k-1];
`endif
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    cla_segment #(
      .SEG(SEG)
    ) u_seg (
      .a     (w_a_st[k][k*SEG +: SEG]),
      .b     (w_b_st[k][k*SEG +: SEG]),
      .c_in  (w_c_st[k]),
      .s     (w_seg_s[k]),
      .c_out (w_seg_co[k]),
      .P     (w_seg_p[k]),
      .G     (w_seg_g[k])
    );
  end

  // Insert each resolved segment into the travelling partial sum; the carry
  // handed to the next stage is rebuilt from the group terms.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      w_sum_nx[k]                = w_sum_st[k];
      w_sum_nx[k][k*SEG +: SEG]  = w_seg_s[k];
      w_cnx[k]                   = w_seg_g[k] | (w_seg_p[k] & w_c_st[k]);
    end
    w_ovf = (w_a_st[L][N-1] == w_b_st[L][N-1]) &&
            (w_sum_nx[L][N-1] != w_a_st[L][N-1]);
    w_res = w_sum_nx[L];
`ifdef PIPELINED_CLA_SATURATE_EN
    if (w_sat_st[L] && w_ovf) begin
      w_res = sat_extreme(w_a_st[L][N-1]);
    end
`endif
  end

  // Stage boundary: registers k = 0..STAGES-1, last one drives the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld_p[k] <= 1'b0;
        r_a_p[k]   <= '0;
        r_b_p[k]   <= '0;
        r_sum_p[k] <= '0;
        r_c_p[k]   <= 1'b0;
`ifdef PIPELINED_CLA_SATURATE_EN
        r_sat_p[k] <= 1'b0;
`endif
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_vld_p[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        r_vld_p[k] <= r_vld_p[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        r_a_p[k]   <= w_a_st[k];
        r_b_p[k]   <= w_b_st[k];
        r_sum_p[k] <= (k == L) ? w_res : w_sum_nx[k];
        r_c_p[k]   <= (k == L) ? w_seg_co[k] : w_cnx[k];
`ifdef PIPELINED_CLA_SATURATE_EN
        r_sat_p[k] <= w_sat_st[k];
`endif
      end
      r_ovf <= w_ovf;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  localparam int N   = 64;
  localparam int SEG = 16;
`ifdef PIPELINED_CLA_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         cin;
  logic         sub;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder #(
    .N   (N),
    .SEG (SEG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .sub       (sub),
`ifdef PIPELINED_CLA_SATURATE_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain wide addition, returns {ovf, cout, sum}.
  function automatic logic [N+1:0] ref_op(input logic [N-1:0] ax, input logic [N-1:0] ay,
                                          input logic acin, input logic asub, input logic asat);
    logic [N-1:0] b;
    logic [N:0]   t;
    logic [N-1:0] s;
    logic         ov;
    b  = asub ? ~ay : ay;
    t  = {1'b0, ax} + {1'b0, b} + {{N{1'b0}}, (asub ? 1'b1 : acin)};
    ov = (ax[N-1] == b[N-1]) && (t[N-1] != ax[N-1]);
    s  = t[N-1:0];
    if (SAT_EN && asat && ov) s = ax[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    return {ov, t[N], s};
  endfunction

  task automatic drive_op(input logic [N-1:0] ax, input logic [N-1:0] ay,
                          input logic acin, input logic asub, input logic asat);
    x = ax; y = ay; cin = acin; sub = asub; sat = asat; in_valid = 1'b1;
  endtask

  // Single operation with hand-computed expectation; checks latency too.
  task automatic run_op(input string tag, input logic [N-1:0] ax, input logic [N-1:0] ay,
                        input logic acin, input logic asub, input logic asat,
                        input logic [N-1:0] esum, input logic ecout, input logic eovf);
    int cnt;
    drive_op(ax, ay, acin, asub, asat);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 4);
    chk({tag, "_sum"}, sum, esum);
    chk({tag, "_cout"}, cout, ecout);
    chk({tag, "_ovf"}, overflow, eovf);
  endtask

  logic [N-1:0] bx [10];
  logic [N-1:0] by [10];
  logic         bcin [10];
  logic         bsub [10];
  logic         bsat [10];
  logic [N+1:0] bexp [10];
  logic [N-1:0] held;
  int           idx;
  int           nout;
  logic         acc;
  logic         cons;

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors.
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0,
           64'd0, 1'b1, 1'b0);
    run_op("borrow", 64'd5, 64'd7, 1'b0, 1'b1, 1'b0,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("cin_add", 64'h0000_0000_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 1'b0,
           64'h0000_0001_0000_0000, 1'b0, 1'b0);
    run_op("sub_ign_cin", 64'd10, 64'd3, 1'b1, 1'b1, 1'b0,
           64'd7, 1'b1, 1'b0);
    run_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("pos_ovf_sat", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 1'b1,
           SAT_EN ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("neg_ovf_sat", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1,
           SAT_EN ? 64'h8000_0000_0000_0000 : 64'd0, 1'b1, 1'b1);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

    // Back-to-back: 10 ops, results on 10 consecutive cycles from cycle 4.
    for (int i = 0; i < 10; i++) begin
      bx[i] = {$urandom, $urandom}; by[i] = {$urandom, $urandom};
      bcin[i] = 1'($urandom_range(0, 1)); bsub[i] = 1'($urandom_range(0, 1));
      bsat[i] = 1'($urandom_range(0, 1));
      bexp[i] = ref_op(bx[i], by[i], bcin[i], bsub[i], bsat[i]);
    end
    drive_op(bx[0], by[0], bcin[0], bsub[0], bsat[0]);
    for (int j = 1; j <= 13; j++) begin
      @(posedge clk); #1;
      if (j >= 4) begin
        chk("burst_vld", out_valid, 1);
        chk("burst_sum", sum, bexp[j-4][N-1:0]);
        chk("burst_cout", cout, bexp[j-4][N]);
        chk("burst_ovf", overflow, bexp[j-4][N+1]);
      end else begin
        chk("burst_bubble", out_valid, 0);
      end
      if (j < 10) drive_op(bx[j], by[j], bcin[j], bsub[j], bsat[j]);
      else in_valid = 1'b0;
    end
    @(posedge clk); #1;

    // Backpressure: consumer stalls for 6 cycles while 6 ops are offered.
    for (int i = 0; i < 6; i++) begin
      bx[i] = {$urandom, $urandom}; by[i] = {$urandom, $urandom};
      bcin[i] = 1'($urandom_range(0, 1)); bsub[i] = 1'($urandom_range(0, 1));
      bsat[i] = 1'b0;
      bexp[i] = ref_op(bx[i], by[i], bcin[i], bsub[i], bsat[i]);
    end
    out_ready = 1'b0;
    idx = 0; nout = 0;
    drive_op(bx[0], by[0], bcin[0], bsub[0], bsat[0]);
    for (int c = 0; c < 40 && nout < 6; c++) begin
      if (c == 6) out_ready = 1'b1;
      #0;
      if (c == 4) held = sum;
      if (c == 4 || c == 5) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_held_sum", sum, bexp[0][N-1:0]);
      end
      if (c == 5) chk("bp_stable", sum, held);
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        chk("bp_order_sum", sum, bexp[nout][N-1:0]);
        chk("bp_order_cout", cout, bexp[nout][N]);
        nout++;
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 6) drive_op(bx[idx], by[idx], bcin[idx], bsub[idx], bsat[idx]);
        else in_valid = 1'b0;
      end
    end
    chk("bp_accepted", idx, 6);
    chk("bp_delivered", nout, 6);
    chk("bp_no_dup", out_valid, 0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      drive_op(64'd100 + 64'(i), 64'd1, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_vld", out_valid, 0);
    chk("midrst_sum", sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", out_valid, 0);
    end
    chk("post_rst_ready", in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
